// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: issues sequential word fetches to instruction
// memory, buffers in-order responses in a small queue and presents the queue
// head to decode. A redirect flushes the queue, restarts fetching at the new
// address and drops every response still in flight at that moment.
//
// Optional feature: define PREFETCH_STALL_CNT_EN to add a 32-bit saturating
// counter output (stall_cnt) that counts cycles with no instruction available.
module instr_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef PREFETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t      mem_q [QDEPTH];
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    cnt_t        count_q, count_d;
    cnt_t        outst_q, outst_d;
    cnt_t        discard_q, discard_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;

    logic        accept;
    logic        push;
    logic        pop;
    logic [CW:0] in_use;
    logic [31:0] redirect_aligned;
    entry_t      head;

    // Slots either holding an instruction or promised to an in-flight fetch.
    assign in_use           = {1'b0, count_q} + {1'b0, outst_q};
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // Request only when a queue slot is guaranteed for the response, so the
    // queue can never overflow. Gating with rst keeps the port quiet in reset.
    assign imem_req  = rst && !redirect && (in_use < (CW+1)'(QDEPTH));
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    // A response is kept only if no discards are pending and no redirect is
    // flushing this cycle. Kept responses are sequential from resp_pc_q, so the
    // issue address is rebuilt instead of stored per outstanding request.
    assign push = imem_rvalid && !redirect && (discard_q == '0);
    assign pop  = inst_valid && inst_ready;

    // Head is driven from registered state; forced to zero while empty.
    assign head       = mem_q[rd_ptr_q];
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? head.word : 32'h0;
    assign inst_pc    = inst_valid ? head.pc   : 32'h0;

    // Next-state logic for fetch address, queue pointers and counters.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        outst_d    = outst_q;

        if (accept && !imem_rvalid) begin
            outst_d = outst_q + 1'b1;
        end else if (!accept && imem_rvalid) begin
            outst_d = outst_q - 1'b1;
        end

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old
            // stream; this also folds in any discards already pending.
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outst_d;
        end else begin
            if (imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Queue storage: write the kept response and its address at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_q gates every read, so stale contents are never visible.
        if (push) begin
            mem_q[wr_ptr_q] <= '{word: imem_rdata, pc: resp_pc_q};
        end
    end

`ifdef PREFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles with nothing for decode, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'h0;
        end else if (!inst_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Stall counter not built: no extra port or state.
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: a per-cycle vector table for the
// stream/back-pressure/redirect path plus hand-written multi-cycle sequences.
// The memory model answers each accepted fetch with ~addr after a fixed latency.
module tb_instr_prefetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef PREFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instr_prefetch #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
`ifdef PREFETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc = 0;
    int    lat = 1;

    // Record acceptances mid-cycle, when the handshake is stable.
    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
        end else if (imem_req && imem_ready) begin
            mq.push_back('{addr: imem_addr, due: cyc + lat});
        end
    end

    // Drive one response per cycle, in order, once its latency has elapsed.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (rst && (mq.size() > 0) && (mq[0].due <= cyc)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~mq[0].addr;
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release just after an edge: that cycle is cycle 0.
    task automatic do_reset(input int l);
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        imem_ready  = 1'b1;
        lat         = l;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Bounded wait for inst_valid; ends sampled at the negedge of the valid cycle.
    task automatic wait_valid(input string name, input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!inst_valid && (n < max_cyc)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(inst_valid), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        imem_ready;
        logic        inst_ready;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        imem_ready  = 1'b1;

        // 1-cycle memory. Decode stalled for 6 cycles: queue fills with 0..12
        // and requests stop; decode then drains; a redirect to 0x103 (-> 0x100)
        // with one response in flight restarts the stream the next cycle.
        //           ird   ir    rdr   rpc           req   addr          vld   pc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h4};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0014, 1'b1, 32'h8};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0018, 1'b1, 32'hC};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h103,      1'b0, 32'h0000_001C, 1'b1, 32'h10};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0108, 1'b1, 32'h100};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_010C, 1'b1, 32'h104};

        // Reset values while rst is low.
        @(negedge clk);
        check("rst_req",   32'(imem_req),   32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst",  inst,            32'h0);
        check("rst_pc",    inst_pc,         32'h0);

        // Table-driven run.
        do_reset(1);
        for (int i = 0; i < 15; i++) begin
            imem_ready  = vecs[i].imem_ready;
            inst_ready  = vecs[i].inst_ready;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].redirect_pc;
            @(negedge clk);
            check($sformatf("vec%0d_req", i),   32'(imem_req),   32'(vecs[i].exp_req));
            check($sformatf("vec%0d_addr", i),  imem_addr,       vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pc", i),    inst_pc,         vecs[i].exp_pc);
            check($sformatf("vec%0d_inst", i),  inst,
                  vecs[i].exp_valid ? ~vecs[i].exp_pc : 32'h0);
            step();
        end
        redirect = 1'b0;

        // Streaming: consecutive pcs 0,4,8,12 once the first one is valid.
        do_reset(1);
        inst_ready = 1'b1;
        wait_valid("stream", 10);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stream_pc%0d", k), inst_pc, 32'(4 * k));
            check($sformatf("stream_inst%0d", k), inst, ~32'(4 * k));
            if (k < 3) @(negedge clk);
        end

        // Redirect to 0x100 with two fetches in flight (3-cycle memory).
        do_reset(3);
        inst_ready = 1'b1;
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        check("rdr_req_low", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("rdr_next_req",  32'(imem_req), 32'd1);
        check("rdr_next_addr", imem_addr,     32'h100);
        wait_valid("rdr", 20);
        check("rdr_pc0",   inst_pc, 32'h100);
        check("rdr_inst0", inst,    ~32'h100);
        @(negedge clk);
        check("rdr_pc1",   inst_pc, 32'h104);

        // Two redirects three cycles apart; only the newest stream is delivered.
        do_reset(3);
        inst_ready = 1'b1;
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        wait_valid("dbl", 30);
        check("dbl_pc0",   inst_pc, 32'h80);
        check("dbl_inst0", inst,    ~32'h80);
        @(negedge clk);
        check("dbl_pc1",   inst_pc, 32'h84);

        // Memory back-pressure: request and address held for 5 cycles.
        do_reset(1);
        inst_ready = 1'b1;
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_req", i),  32'(imem_req), 32'd1);
            check($sformatf("hold%0d_addr", i), imem_addr,     32'h0);
            step();
        end
        imem_ready = 1'b1;
        @(negedge clk);
        check("hold_accept_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("hold_after_addr", imem_addr, 32'h4);

        // Asynchronous reset in mid-operation, then a clean restart at RESET_PC.
        wait_valid("pre_rst", 10);
        #2;
        rst = 1'b0;
        #1;
        check("async_req",   32'(imem_req),   32'd0);
        check("async_valid", 32'(inst_valid), 32'd0);
        check("async_inst",  inst,            32'h0);
        check("async_pc",    inst_pc,         32'h0);
        do_reset(1);
        inst_ready = 1'b1;
        @(negedge clk);
        check("restart_req",  32'(imem_req), 32'd1);
        check("restart_addr", imem_addr,     32'h0);
        wait_valid("restart", 10);
        check("restart_pc0", inst_pc, 32'h0);
        @(negedge clk);
        check("restart_pc1", inst_pc, 32'h4);

        // Address wrap: redirect low bits ignored, 0xFFFF_FFFC rolls over to 0.
        do_reset(1);
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        check("wrap_req_low", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wrap", 10);
        check("wrap_pc0",   inst_pc, 32'hFFFF_FFFC);
        check("wrap_inst0", inst,    32'h0000_0003);
        @(negedge clk);
        check("wrap_pc1",   inst_pc, 32'h0);
        check("wrap_inst1", inst,    32'hFFFF_FFFF);

`ifdef PREFETCH_STALL_CNT_EN
        // Stall counter: 3-cycle memory gives 4 empty cycles before first valid.
        do_reset(3);
        inst_ready = 1'b0;
        wait_valid("stall", 20);
        check("stall_first", stall_cnt, 32'd4);
        @(negedge clk);
        check("stall_hold",  stall_cnt, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
